// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver. Synchronizes the serial line,
// confirms the start bit at mid-bit, shifts in NB_DATA bits LSB first and
// checks the stop bit. A good frame updates o_data with a one-clk o_rxDone
// pulse. A low stop bit gives a one-clk o_frame_err pulse and the byte is
// discarded.
module uart_rx_framer #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 16,
  parameter int NB_TICK = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxDone,
  output logic               o_frame_err,
  output logic               o_busy
);

  // The tick counter has to reach the longer of the bit period and the stop span.
  localparam int TICK_MAX = (NB_TICK > NB_STOP) ? NB_TICK : NB_STOP;
  localparam int NB_TCNT  = $clog2(TICK_MAX) + 1;
  localparam int NB_BCNT  = $clog2(NB_DATA) + 1;

  // Counter values at which each state acts on a tick.
  localparam logic [NB_TCNT-1:0] TICK_HALF = NB_TCNT'(NB_TICK / 2 - 1);
  localparam logic [NB_TCNT-1:0] TICK_LAST = NB_TCNT'(NB_TICK - 1);
  localparam logic [NB_TCNT-1:0] STOP_LAST = NB_TCNT'(NB_STOP - 1);
  localparam logic [NB_BCNT-1:0] BIT_LAST  = NB_BCNT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [NB_TCNT-1:0]   tick_cnt_q;
  logic [NB_BCNT-1:0]   bit_cnt_q;
  logic [NB_DATA-1:0]   shift_q;
  logic [NB_DATA-1:0]   data_q;
  logic                 rx_done_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic [1:0]           sync_q;
  logic                 rx_s;

  // Two-flop synchronizer on the asynchronous line. It resets to the idle
  // level so that reset never appears as a start edge.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign rx_s = sync_q[1];

  // Receive FSM: counters, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Both status outputs are single-cycle pulses, so they drop back by default.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A low line starts a frame immediately and does not wait for a tick.
          if (!rx_s) begin
            state_q    <= ST_START;
            busy_q     <= 1'b1;
            tick_cnt_q <= '0;
          end else begin
            busy_q     <= 1'b0;
          end
        end
        ST_START: begin
          if (i_tick) begin
            if (tick_cnt_q == TICK_HALF) begin
              if (!rx_s) begin
                // Still low at mid start bit, so this is a real frame.
                state_q    <= ST_DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                // The line is high again, so this was a glitch. Drop it silently.
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                tick_cnt_q <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q;
          end
        end
        ST_DATA: begin
          if (i_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              // Sample at mid-bit. Bits arrive LSB first, so shift right.
              shift_q    <= {rx_s, shift_q[NB_DATA-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == BIT_LAST) begin
                state_q   <= ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q;
          end
        end
        ST_STOP: begin
          if (i_tick) begin
            if (tick_cnt_q == STOP_LAST) begin
              if (rx_s) begin
                data_q      <= shift_q;
                rx_done_q   <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
              // Leave at mid stop bit, so the next start edge can be seen right away.
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_rxDone    = rx_done_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed frames with hand-computed expected bytes for
// uart_rx_framer at its default parameters.
module tb_uart_rx_framer;

  logic       clk;
  logic       i_rst;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rxDone;
  logic       o_frame_err;
  logic       o_busy;

  int n_pass   = 0;
  int n_checks = 0;
  int tick_div = 1;

  logic [7:0] got_q[$];
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int long_cnt    = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  uart_rx_framer #(.NB_DATA(8), .NB_STOP(16), .NB_TICK(16)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rxDone    (o_rxDone),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold the line at rx for n ticks. Each tick is one clk with i_tick high,
  // followed by tick_div-1 clks with i_tick low.
  task automatic hold_ticks(input logic rx, input int n);
    repeat (n) begin
      @(negedge clk);
      i_rx   = rx;
      i_tick = 1'b1;
      repeat (tick_div - 1) begin
        @(negedge clk);
        i_tick = 1'b0;
      end
    end
  endtask

  // Send one frame. p100 is the bit length in hundredths of a tick
  // (1600 is nominal). Bit boundaries are floored, so skew accumulates.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int p100);
    logic v;
    int   n;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) v = 1'b0;
      else if (b == 9) v = stop_bit;
      else v = d[b-1];
      n = ((b + 1) * p100) / 100 - (b * p100) / 100;
      hold_ticks(v, n);
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    i_rst  = 1'b1;
    i_tick = 1'b1;
    i_rx   = 1'b0;
    repeat (cycles) @(negedge clk);
    i_rst  = 1'b0;
    i_rx   = 1'b1;
  endtask

  // Output monitor: logs bytes, error pulses, overlaps and pulses wider than one clk.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_rxDone === 1'b1) begin
        got_q.push_back(o_data);
        if (prev_done) long_cnt++;
      end
      if (o_frame_err === 1'b1) begin
        err_cnt++;
        if (prev_err) long_cnt++;
      end
      if (o_rxDone === 1'b1 && o_frame_err === 1'b1) overlap_cnt++;
      prev_done = (o_rxDone === 1'b1);
      prev_err  = (o_frame_err === 1'b1);
    end
  end

  // Watchdog so that a stuck run still ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin
    i_rst  = 1'b1;
    i_tick = 1'b0;
    i_rx   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data", o_data, 8'h00);
    check_eq("rst_done", o_rxDone, 1'b0);
    check_eq("rst_err", o_frame_err, 1'b0);
    check_eq("rst_busy", o_busy, 1'b0);
    i_rst = 1'b0;
    hold_ticks(1'b1, 20);

    // Single frame 0x08 with i_tick every third clk.
    tick_div = 3;
    send_frame(8'h08, 1'b1, 1600);
    hold_ticks(1'b1, 20);
    tick_div = 1;
    check_eq("f08_count", got_q.size(), 1);
    check_eq("f08_data", o_data, 8'h08);
    check_eq("f08_err", err_cnt, 0);

    // Back-to-back frames with no idle gap, i_tick every clk.
    send_frame(8'h08, 1'b1, 1600);
    send_frame(8'h05, 1'b1, 1600);
    send_frame(8'h20, 1'b1, 1600);
    hold_ticks(1'b1, 20);
    check_eq("b2b_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_eq("b2b_d0", got_q[1], 8'h08);
      check_eq("b2b_d1", got_q[2], 8'h05);
      check_eq("b2b_d2", got_q[3], 8'h20);
    end
    check_eq("b2b_out", o_data, 8'h20);

    // A 4-tick low glitch must be rejected.
    hold_ticks(1'b0, 4);
    hold_ticks(1'b1, 30);
    check_eq("glitch_count", got_q.size(), 4);
    check_eq("glitch_err", err_cnt, 0);
    check_eq("glitch_data", o_data, 8'h20);
    check_eq("glitch_busy", o_busy, 1'b0);

    // 0xA5 with a low stop bit gives a framing error and keeps o_data.
    send_frame(8'hA5, 1'b0, 1600);
    hold_ticks(1'b1, 30);
    check_eq("ferr_err", err_cnt, 1);
    check_eq("ferr_count", got_q.size(), 4);
    check_eq("ferr_data", o_data, 8'h20);

    // Reset during bit 4 of 0xFF, then a clean 0x3C.
    hold_ticks(1'b0, 16);
    hold_ticks(1'b1, 64 + 8);
    check_eq("mid_busy", o_busy, 1'b1);
    pulse_reset(2);
    check_eq("mrst_busy", o_busy, 1'b0);
    check_eq("mrst_data", o_data, 8'h00);
    hold_ticks(1'b1, 100);
    check_eq("mrst_count", got_q.size(), 4);
    check_eq("mrst_err", err_cnt, 1);
    send_frame(8'h3C, 1'b1, 1600);
    hold_ticks(1'b1, 20);
    check_eq("f3c_count", got_q.size(), 5);
    check_eq("f3c_data", o_data, 8'h3C);

    // 0x55 at +3% and -3% baud skew.
    send_frame(8'h55, 1'b1, 1648);
    hold_ticks(1'b1, 20);
    check_eq("skewp_count", got_q.size(), 6);
    check_eq("skewp_data", o_data, 8'h55);
    send_frame(8'hAA, 1'b1, 1600);
    send_frame(8'h55, 1'b1, 1552);
    hold_ticks(1'b1, 20);
    check_eq("skewm_count", got_q.size(), 8);
    check_eq("skewm_data", o_data, 8'h55);
    check_eq("skew_err", err_cnt, 1);

    check_eq("overlap", overlap_cnt, 0);
    check_eq("pulse_width", long_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame.
REQ-002 Parameter NB_STOP, default 16, oversampling ticks spanned by the stop bit.
REQ-003 Parameter NB_TICK, default 16, oversampling ticks per data bit (start/data).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_tick  input  1  oversampling strobe from baud generator, one clk wide, NB_TICK per bit period.
REQ-007 i_rx  input  1  asynchronous serial line, idle high.
REQ-008 o_data  output  NB_DATA  last correctly framed byte, LSB received first.
REQ-009 o_rxDone  output  1  one-clk pulse: o_data updated with a new valid byte.
REQ-010 o_frame_err  output  1  one-clk pulse: stop bit sampled low, byte discarded.
REQ-011 o_busy  output  1  high while state is not IDLE.

Function
REQ-012 i_rx SHALL pass a 2-FF synchronizer (reset value 1); all sampling uses the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; tick counter ceil(log2(max(NB_TICK,NB_STOP)))+1 bits; bit counter log2(NB_DATA)+1 bits; shift register NB_DATA bits.
REQ-014 Tick counter SHALL advance only on clk cycles with i_tick=1; no state change except IDLE->START occurs without i_tick.
REQ-015 IDLE: rx_s=0 -> START, tick counter cleared; else stay.
REQ-016 START: on i_tick with counter=NB_TICK/2-1: rx_s=0 -> DATA, counters cleared; rx_s=1 -> IDLE, no output pulse (glitch rejection); otherwise counter+1.
REQ-017 DATA: on i_tick with counter=NB_TICK-1: shift right, rx_s into MSB, counter cleared; bit counter=NB_DATA-1 -> STOP, else bit counter+1.
REQ-018 STOP: on i_tick with counter=NB_STOP-1: rx_s=1 -> o_data<=shift register, o_rxDone=1 next cycle; rx_s=0 -> o_frame_err=1, o_data unchanged; both -> IDLE.
REQ-019 o_rxDone and o_frame_err SHALL never assert together and SHALL last exactly one clk.
REQ-020 o_data SHALL hold its value between o_rxDone pulses; unaffected by glitches or framing errors.
REQ-021 From IDLE, a new start edge SHALL be accepted the cycle after returning to IDLE (back-to-back frames, no idle gap needed).
REQ-022 Line held low after a framing error SHALL be treated as a new start bit once back in IDLE (break retriggers; no lockout).
REQ-023 i_tick asserted every clk SHALL be legal; behaviour identical in tick count.

Reset
REQ-024 i_rst=1 at a clk edge SHALL force: state IDLE, counters 0, shift register 0, synchronizer 11, o_data 0, o_rxDone 0, o_frame_err 0, o_busy 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no o_rxDone/o_frame_err pulse; reception restarts on next falling edge after release.
REQ-026 Reset SHALL take priority over i_tick and i_rx.

Verification
REQ-027 Frame 0x08 (start, bits 0,0,0,1,0,0,0,0, stop), 16 ticks/bit -> one o_rxDone, o_data=0x08, o_frame_err=0.
REQ-028 Back-to-back 0x08, 0x05, 0x20 with zero idle -> three o_rxDone pulses, o_data 0x08, 0x05, 0x20 in order.
REQ-029 Low pulse of 4 ticks on idle line -> returns to IDLE, no pulses, o_data unchanged.
REQ-030 Frame 0xA5 with stop bit low -> o_frame_err pulse once, o_rxDone 0, o_data keeps prior 0x20.
REQ-031 i_rst pulsed during bit 4 of 0xFF, then frame 0x3C -> no pulse for aborted frame, then o_rxDone with o_data=0x3C.
REQ-032 Baud ±3% skew on 0x55 with NB_TICK=16 -> o_data=0x55, no frame error.
